// File: rtl/mips_bus_pkg.sv
// Shared types and default widths for the Avalon-style memory bus and its two-master arbiter.
package mips_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] address;
        logic                  read;
        logic                  write;
        logic [BUS_BE_W-1:0]   byteenable;
        logic [BUS_DATA_W-1:0] writedata;
    } bus_req_t;

endpackage

// File: rtl/avalon_bus_arbiter_2m_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
module rr_pick2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);

    // Choose the winner among the valid requesters.
    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_idx   = 1'b0;
        if (valid0 && valid1) begin
            gnt_idx = ~last;
        end else if (valid1) begin
            gnt_idx = 1'b1;
        end else begin
            gnt_idx = 1'b0;
        end
    end

endmodule

// File: rtl/avalon_bus_arbiter_2m.sv
// Two-master, one-slave Avalon-style arbiter: one transfer per grant, round-robin on ties,
// sticky flag when a master drives read and write together.
module avalon_bus_arbiter_2m
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W     = BUS_ADDR_W,
    parameter int DATA_W     = BUS_DATA_W,
    parameter int FIRST_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_waitrequest,
    output logic [1:0]          grant,
    output logic                err_rw
);

    localparam int   BE_W     = DATA_W / 8;
    // last-granted starts as the other master so FIRST_PRIO wins the first tie
    localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       last_r;
    logic       last_nxt_s;
    logic       err_r;
    logic       m0_valid_s;
    logic       m1_valid_s;
    logic       own_valid_s;
    logic       rw_clash_s;
    logic       pick_valid_s;
    logic       pick_idx_s;

    assign m0_valid_s = m0_read ^ m0_write;
    assign m1_valid_s = m1_read ^ m1_write;
    assign rw_clash_s = (m0_read & m0_write) | (m1_read & m1_write);

    rr_pick2 u_pick (
        .valid0    (m0_valid_s),
        .valid1    (m1_valid_s),
        .last      (last_r),
        .gnt_valid (pick_valid_s),
        .gnt_idx   (pick_idx_s)
    );

    // Arbiter state, last-granted master and sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            last_r  <= LAST_RST;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
            err_r   <= err_r | rw_clash_s;
        end
    end

    // Next state: grant from IDLE, release on completion or when the owner withdraws.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        own_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = pick_idx_s ? OWN1 : OWN0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0, OWN1: begin
                own_valid_s = (state_r == OWN1) ? m1_valid_s : m0_valid_s;
                // An owner that is no longer valid has aborted; last-granted stays put
                if (!own_valid_s) begin
                    state_nxt_s = IDLE;
                end else if (!s_waitrequest) begin
                    state_nxt_s = IDLE;
                    last_nxt_s  = (state_r == OWN1);
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Slave-side mux and per-master stall; strobes are masked so read and write never meet.
    always_comb begin
        s_address      = {ADDR_W{1'b0}};
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_byteenable   = {BE_W{1'b0}};
        s_writedata    = {DATA_W{1'b0}};
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = 2'b00;
        case (state_r)
            IDLE: begin
                grant = 2'b00;
            end
            OWN0: begin
                grant          = 2'b01;
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                s_read         = m0_read & m0_valid_s;
                s_write        = m0_write & m0_valid_s;
                m0_waitrequest = m0_valid_s ? s_waitrequest : 1'b1;
            end
            OWN1: begin
                grant          = 2'b10;
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                s_read         = m1_read & m1_valid_s;
                s_write        = m1_write & m1_valid_s;
                m1_waitrequest = m1_valid_s ? s_waitrequest : 1'b1;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign err_rw      = err_r;

endmodule

// File: tb/tb_avalon_bus_arbiter_2m.sv
// Self-checking bench for avalon_bus_arbiter_2m: directed scenarios plus random traffic
// compared every cycle against a transaction-level arbitration model.
module tb_avalon_bus_arbiter_2m;
    import mips_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [1:0]  grant;
    logic        err_rw;

    avalon_bus_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .FIRST_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant), .err_rw(err_rw)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: owner -1 means nobody holds the bus
    int owner = -1;
    int last_g = 1;
    bit err_m = 1'b0;
    int done_k = -1;
    bit started = 1'b0;
    int done_log[$];

    bus_req_t q0[$], q1[$];
    bus_req_t cur0, cur1;
    bit busy0, busy1;
    int gap0, gap1;
    int force_rw1 = 0;
    int fixed_wait = 0;
    bit rand_gap = 1'b0;
    int wcnt, wtarget;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit vld(input int k);
        return (k == 0) ? (m0_read ^ m0_write) : (m1_read ^ m1_write);
    endfunction

    task automatic check_outputs();
        logic [1:0]  eg;
        logic        esr, esw, ew0, ew1;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        eg = 2'b00; esr = 1'b0; esw = 1'b0; ew0 = 1'b1; ew1 = 1'b1;
        ea = 32'h0; ewd = 32'h0; ebe = 4'h0;
        if (owner == 0) begin
            eg = 2'b01; ea = m0_address; ebe = m0_byteenable; ewd = m0_writedata;
            if (vld(0)) begin esr = m0_read; esw = m0_write; ew0 = s_waitrequest; end
        end else if (owner == 1) begin
            eg = 2'b10; ea = m1_address; ebe = m1_byteenable; ewd = m1_writedata;
            if (vld(1)) begin esr = m1_read; esw = m1_write; ew1 = s_waitrequest; end
        end
        chk("grant", grant, eg);
        chk("s_read", s_read, esr);
        chk("s_write", s_write, esw);
        chk("s_address", s_address, ea);
        chk("s_byteenable", s_byteenable, ebe);
        chk("s_writedata", s_writedata, ewd);
        chk("m0_waitrequest", m0_waitrequest, ew0);
        chk("m1_waitrequest", m1_waitrequest, ew1);
        chk("m0_readdata", m0_readdata, s_readdata);
        chk("m1_readdata", m1_readdata, s_readdata);
        chk("err_rw", err_rw, err_m);
        chk("rw_exclusive", s_read & s_write, 1'b0);
    endtask

    task automatic model_update();
        done_k = -1;
        started = 1'b0;
        if (reset) begin
            owner = -1; last_g = 1; err_m = 1'b0;
        end else begin
            if ((m0_read && m0_write) || (m1_read && m1_write)) err_m = 1'b1;
            if (owner < 0) begin
                if (vld(0) && vld(1)) owner = 1 - last_g;
                else if (vld(0)) owner = 0;
                else if (vld(1)) owner = 1;
                started = (owner >= 0);
            end else if (!vld(owner)) begin
                owner = -1;
            end else if (!s_waitrequest) begin
                last_g = owner; done_k = owner; owner = -1;
                done_log.push_back(done_k);
            end
        end
    endtask

    task automatic tick(input bit do_check);
        #1;
        if (do_check) check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = 4'h0; m0_writedata = 32'h0;
        m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = 4'h0; m1_writedata = 32'h0;
        s_readdata = 32'h0; s_waitrequest = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_m0_wait", m0_waitrequest, 1'b1);
        chk("rst_m1_wait", m1_waitrequest, 1'b1);
        chk("rst_s_strobes", {s_read, s_write}, 2'b00);
        chk("rst_err_rw", err_rw, 1'b0);
        done_log.delete();
        busy0 = 1'b0; busy1 = 1'b0; gap0 = 0; gap1 = 0;
    endtask

    function automatic bus_req_t mk_req(input bit wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus_req_t r;
        r.address = a; r.read = ~wr; r.write = wr; r.byteenable = be; r.writedata = d;
        return r;
    endfunction

    function automatic bus_req_t rand_req();
        return mk_req(1'($urandom), $urandom, 4'($urandom), $urandom);
    endfunction

    task automatic drive_masters();
        m0_address = cur0.address; m0_byteenable = cur0.byteenable; m0_writedata = cur0.writedata;
        m0_read = busy0 & cur0.read; m0_write = busy0 & cur0.write;
        m1_address = cur1.address; m1_byteenable = cur1.byteenable; m1_writedata = cur1.writedata;
        m1_read = busy1 & cur1.read; m1_write = busy1 & cur1.write;
        if (force_rw1 > 0) begin
            m1_read = 1'b1; m1_write = 1'b1; force_rw1--;
        end
    endtask

    // Masters hold each request until the model sees it complete; slave stalls wtarget cycles.
    task automatic run_engine(input int max_cycles, output int cyc);
        cyc = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy0 || busy1 || owner >= 0 || force_rw1 > 0)
               && cyc < max_cycles) begin
            if (!busy0 && gap0 == 0 && q0.size() > 0) begin cur0 = q0.pop_front(); busy0 = 1'b1; end
            else if (gap0 > 0) gap0--;
            if (!busy1 && gap1 == 0 && q1.size() > 0) begin cur1 = q1.pop_front(); busy1 = 1'b1; end
            else if (gap1 > 0) gap1--;
            drive_masters();
            s_waitrequest = (owner >= 0) && (wcnt < wtarget);
            s_readdata = $urandom;
            tick(1'b1);
            if (started) begin
                wcnt = 0;
                wtarget = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end else if (owner >= 0) begin
                wcnt++;
            end
            if (done_k == 0) begin busy0 = 1'b0; if (rand_gap) gap0 = int'($urandom_range(0, 2)); end
            if (done_k == 1) begin busy1 = 1'b0; if (rand_gap) gap1 = int'($urandom_range(0, 2)); end
            cyc++;
        end
        chk("engine_budget", cyc < max_cycles, 1'b1);
        clear_inputs();
        tick(1'b1);
    endtask

    task automatic chk_log(input string tag, input int exp[$]);
        chk({tag, "_count"}, done_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < done_log.size(); i++)
            chk(tag, done_log[i], exp[i]);
    endtask

    initial begin
        int cyc;
        int exp_q[$];
        reset = 1'b1;
        clear_inputs();
        cur0 = mk_req(1'b0, 32'h0, 4'h0, 32'h0);
        cur1 = cur0;
        @(negedge clk);

        // single read with two wait cycles
        do_reset();
        m0_read = 1'b1; m0_address = 32'h0000_0010; m0_byteenable = 4'hF;
        s_readdata = 32'hDEAD_BEEF;
        tick(1'b1);
        chk("sr_grant", grant, 2'b01);
        tick(1'b1);
        tick(1'b1);
        s_waitrequest = 1'b0;
        #1;
        chk("sr_m0_wait_low", m0_waitrequest, 1'b0);
        chk("sr_m0_readdata", m0_readdata, 32'hDEAD_BEEF);
        chk("sr_m1_wait", m1_waitrequest, 1'b1);
        tick(1'b1);
        chk("sr_idle_after", grant, 2'b00);
        clear_inputs();
        tick(1'b1);

        // contention, then a repeated tie
        do_reset();
        fixed_wait = 0; rand_gap = 1'b0;
        q0.push_back(mk_req(1'b1, 32'h100, 4'hF, 32'h1111_1111));
        q1.push_back(mk_req(1'b0, 32'h200, 4'hF, 32'h0));
        run_engine(50, cyc);
        chk("cont_cycles", cyc, 4);
        q0.push_back(mk_req(1'b1, 32'h100, 4'hF, 32'h1111_1111));
        q1.push_back(mk_req(1'b0, 32'h200, 4'hF, 32'h0));
        run_engine(50, cyc);
        exp_q = '{0, 1, 0, 1};
        chk_log("cont_order", exp_q);

        // fairness: four back-to-back requests per master
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        run_engine(100, cyc);
        chk("fair_cycles", cyc, 16);
        exp_q = '{0, 1, 0, 1, 0, 1, 0, 1};
        chk_log("fair_order", exp_q);

        // protocol error on M1 while M0 keeps working
        do_reset();
        fixed_wait = 1;
        q0.push_back(rand_req());
        q0.push_back(rand_req());
        force_rw1 = 3;
        run_engine(50, cyc);
        chk("perr_err_rw", err_rw, 1'b1);
        exp_q = '{0, 0};
        chk_log("perr_order", exp_q);
        do_reset();
        chk("perr_cleared", err_rw, 1'b0);

        // abort keeps last-granted, so the next tie still goes to M0
        do_reset();
        m0_read = 1'b1; m0_address = 32'h40; s_waitrequest = 1'b1;
        tick(1'b1);
        chk("ab_grant", grant, 2'b01);
        m0_read = 1'b0;
        tick(1'b1);
        chk("ab_idle", grant, 2'b00);
        m0_read = 1'b1; m1_write = 1'b1; m1_address = 32'h80;
        tick(1'b1);
        chk("ab_tie_grant", grant, 2'b01);
        s_waitrequest = 1'b0;
        tick(1'b1);
        clear_inputs();
        tick(1'b1);

        // reset while M1 owns the bus
        do_reset();
        m1_write = 1'b1; m1_address = 32'hC0; m1_writedata = 32'h5A5A_5A5A; s_waitrequest = 1'b1;
        tick(1'b1);
        chk("rs_grant", grant, 2'b10);
        reset = 1'b1;
        tick(1'b1);
        chk("rs_grant_idle", grant, 2'b00);
        chk("rs_strobes", {s_read, s_write}, 2'b00);
        chk("rs_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
        reset = 1'b0;
        clear_inputs();
        tick(1'b1);

        // random traffic
        do_reset();
        fixed_wait = -1; rand_gap = 1'b1;
        for (int i = 0; i < 40; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        run_engine(3000, cyc);
        chk("rand_done", done_log.size(), 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
